// File: rtl/bcd_updown_counter_if.sv
// Signal bundle for bcd_updown_counter: control/load inputs and count/flag outputs.
// There is no handshake; the master drives the controls and the slave responds every clock.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
) ();
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   out;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  out, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output out, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit modulo-N up/down counter with parallel load, terminal count and wrap pulse.
// Ripple carry/borrow across all digits resolves within a single cycle.
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int MODULO = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_updown_counter_if.slave   bus
);
    localparam logic [3:0] MAX = 4'(MODULO - 1);

    logic [4*DIGITS-1:0] out_q, out_d;
    logic                wrap_q, wrap_d;
    logic                load_err_q, load_err_d;
    logic                all_max, all_zero;
    logic                carry;
    logic [3:0]          dig;

    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (out_q[4*i +: 4] != MAX)  all_max  = 1'b0;
            if (out_q[4*i +: 4] != 4'd0) all_zero = 1'b0;
        end
    end

    always_comb begin
        out_d      = out_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        carry      = 1'b1;
        dig        = 4'd0;
        if (bus.load) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = bus.load_val[4*i +: 4];
                if ({1'b0, dig} >= 5'(MODULO)) begin
                    out_d[4*i +: 4] = 4'd0;
                    load_err_d      = 1'b1;
                end else begin
                    out_d[4*i +: 4] = dig;
                end
            end
        end else if (bus.en) begin
            // carry doubles as borrow; it survives the loop only when every digit rolled
            for (int i = 0; i < DIGITS; i++) begin
                dig = out_q[4*i +: 4];
                if (carry) begin
                    if (bus.up) begin
                        if (dig == MAX) begin
                            out_d[4*i +: 4] = 4'd0;
                        end else begin
                            out_d[4*i +: 4] = dig + 4'd1;
                            carry           = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            out_d[4*i +: 4] = MAX;
                        end else begin
                            out_d[4*i +: 4] = dig - 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q      <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.out      = out_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.en & (bus.up ? all_max : all_zero);
endmodule
